shake_perm_ctrl: RTL and testbench
==================================

# shake_perm_ctrl

Second-stage controller of the SHAKE core. Takes a filled input buffer from the load stage, sequences absorption of each rate block into the Keccak state and runs the 24-round Keccak-f permutation. After the last block it runs the squeeze phase, handing rate blocks to the output buffer until the requested output length is produced.

## Interface
Parameters:
- `ROUNDS`, 24, Keccak-f rounds per permutation; must be even.
- `OUT_LEN_W`, 32, width of the output-length field (units: 64-bit words).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: header accepted by the load stage; latch `mode` and `out_words`.
- `mode` in 1: 0 = SHAKE128 (rate 21 words), 1 = SHAKE256 (rate 17 words).
- `out_words` in OUT_LEN_W: requested output length in 64-bit words.
- `input_buffer_ready` in 1: load stage has a full, padded block ready.
- `last_block_in_buffer` in 1: that block is the final one; sampled with `input_buffer_ready`.
- `input_buffer_consumed` out 1: one-cycle ack; the load stage may refill the buffer.
- `state_reset` out 1: clear the Keccak state.
- `absorb_enable` out 1: XOR the buffer into the state rate portion.
- `round_enable` out 1: apply the round(s) selected by `round_index`.
- `round_index` out 5: current round number.
- `output_buffer_empty` in 1: output PISO can accept a block.
- `output_buffer_load` out 1: copy the state rate portion into the output PISO.
- `last_output_block` out 1: qualifies `output_buffer_load` as the final block.
- `last_block_words` out 5: valid words in the final block (1..rate).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the operation completes.

## Operation
- States: IDLE, WAIT_BLOCK, ABSORB, PERMUTE, SQUEEZE_WAIT, SQUEEZE.
- **IDLE**
  - On `start`: latch `mode` and `out_words` into `words_left`.
  - Pulse `state_reset`, then go to WAIT_BLOCK.
  - `start` outside IDLE is ignored.
- **WAIT_BLOCK**
  - On `input_buffer_ready`: latch `last_block_in_buffer` into `last_q` and go to ABSORB.
- **ABSORB** (1 cycle)
  - Assert `absorb_enable` and `input_buffer_consumed`.
  - Clear the round counter, then go to PERMUTE.
- **PERMUTE**
  - Assert `round_enable` with `round_index` = counter; counter increments by 1 each cycle.
  - At `ROUNDS-1`:
    - `last_q`=0: go to WAIT_BLOCK.
    - `last_q`=1 and `words_left`=0: pulse `done`, go to IDLE.
    - `last_q`=1 and `words_left`≠0: go to SQUEEZE_WAIT.
- **SQUEEZE_WAIT**
  - On `output_buffer_empty`: go to SQUEEZE.
- **SQUEEZE** (1 cycle)
  - Assert `output_buffer_load`.
  - If `words_left` ≤ rate:
    - Assert `last_output_block` with `last_block_words` = `words_left`.
    - Set `words_left` to 0, pulse `done`, go to IDLE.
  - Else: `words_left` -= rate; clear the counter; go to PERMUTE.
- Rate is selected by the latched mode only; `mode` changes during busy are ignored.
- `words_left` never underflows.

## Timing
- Reset: state IDLE, counter 0, `words_left` 0, `last_q` 0. All outputs 0.
- Reset mid-operation aborts to IDLE immediately; no `done` is issued.
- All outputs are combinational from state/counter (Moore); no input-to-output combinational path except the state decisions above.
- Per input block: 1 (ABSORB) + ROUNDS cycles, plus a minimum of 1 cycle in WAIT_BLOCK.
- `start` to first `absorb_enable`: minimum 2 cycles (IDLE→WAIT_BLOCK, WAIT_BLOCK→ABSORB with ready high).
- Per extra squeeze block: ROUNDS + 1 cycles, plus SQUEEZE_WAIT stall time.
- `input_buffer_ready` is held high by the load stage until `input_buffer_consumed`; holding it high across PERMUTE is legal and ignored.
- `done` and `output_buffer_load` can coincide with the final squeeze cycle.

## Configuration
- `SHAKE_DOUBLE_ROUND_EN` defined:
  - `round_enable` applies rounds `round_index` and `round_index`+1 in one cycle.
  - Counter steps by 2; `round_index` is always even.
  - PERMUTE lasts ROUNDS/2 cycles and ends at counter `ROUNDS-2`.
- Undefined: one round per cycle as described above.

## Structure
- Shared package `shake_pkg`:
  - `mode_t`.
  - `RATE_WORDS_128`=21 and `RATE_WORDS_256`=17.
  - `KECCAK_ROUNDS`=24.
  - Controller state enum `perm_state_t`.
- Natural sub-module: `keccak_round_counter`.
  - Clear/enable/step inputs; `last` output; step width set by `SHAKE_DOUBLE_ROUND_EN`.

## Test plan
- Reset mid-PERMUTE (counter=10), `rst_n` low → all outputs 0 the same cycle; IDLE after release; no `done`.
- SHAKE128, `out_words`=4, single last block → ABSORB, 24 round cycles (index 0..23), one SQUEEZE with `last_output_block`=1, `last_block_words`=4, then `done`.
- SHAKE256, `out_words`=40, 2 input blocks → 2 absorbs (`input_buffer_consumed` twice), then squeezes of 17 and 17 words, then a final squeeze with `last_block_words`=6; PERMUTE cycles between them.
- `out_words`=0 → after permutation, `done` with no `output_buffer_load`.
- `output_buffer_empty` held low 7 cycles in SQUEEZE_WAIT → no load during the stall; load on the first empty cycle; `start` pulsed while busy is ignored.
- With `SHAKE_DOUBLE_ROUND_EN` → PERMUTE lasts 12 cycles with `round_index` 0,2,…,22.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared SHAKE definitions: hash mode, rate sizes, round count and the
// permutation controller state encoding.
package shake_pkg;

    typedef enum logic {
        MODE_SHAKE128 = 1'b0,
        MODE_SHAKE256 = 1'b1
    } mode_t;

    localparam int RATE_WORDS_128 = 21;
    localparam int RATE_WORDS_256 = 17;
    localparam int KECCAK_ROUNDS  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BLOCK,
        ST_ABSORB,
        ST_PERMUTE,
        ST_SQUEEZE_WAIT,
        ST_SQUEEZE
    } perm_state_t;

    function automatic logic [4:0] rate_words(input mode_t m);
        return (m == MODE_SHAKE256) ? 5'(RATE_WORDS_256) : 5'(RATE_WORDS_128);
    endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Keccak-f round counter; advances by two per enabled cycle when
// SHAKE_DOUBLE_ROUND_EN is defined, otherwise by one.
module keccak_round_counter #(
    parameter int ROUNDS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [4:0] count,
    output logic       last
);

`ifdef SHAKE_DOUBLE_ROUND_EN
    localparam logic [4:0] STEP = 5'd2;
`else
    localparam logic [4:0] STEP = 5'd1;
`endif
    localparam logic [4:0] LAST_IDX = 5'(ROUNDS) - STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 5'd0;
        end else if (clear) begin
            count <= 5'd0;
        end else if (enable) begin
            count <= count + STEP;
        end
    end

    assign last = (count == LAST_IDX);

endmodule

// File: rtl/shake_perm_ctrl.sv
// SHAKE absorb/permute/squeeze sequencer between the load stage and the
// output PISO. Define SHAKE_DOUBLE_ROUND_EN for two Keccak rounds per cycle.
module shake_perm_ctrl
    import shake_pkg::*;
#(
    parameter int ROUNDS    = KECCAK_ROUNDS,
    parameter int OUT_LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [OUT_LEN_W-1:0] out_words,
    input  logic                 input_buffer_ready,
    input  logic                 last_block_in_buffer,
    output logic                 input_buffer_consumed,
    output logic                 state_reset,
    output logic                 absorb_enable,
    output logic                 round_enable,
    output logic [4:0]           round_index,
    input  logic                 output_buffer_empty,
    output logic                 output_buffer_load,
    output logic                 last_output_block,
    output logic [4:0]           last_block_words,
    output logic                 busy,
    output logic                 done
);

    perm_state_t          state, state_next;
    mode_t                mode_q;
    logic [OUT_LEN_W-1:0] words_left;
    logic                 last_q;
    logic                 state_reset_q;
    logic                 cnt_clear, cnt_en, cnt_last;
    logic [4:0]           cnt;
    logic [OUT_LEN_W-1:0] rate_ext;
    logic                 final_squeeze;

    keccak_round_counter #(.ROUNDS(ROUNDS)) u_round_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt),
        .last   (cnt_last)
    );

    assign rate_ext      = OUT_LEN_W'(rate_words(mode_q));
    assign final_squeeze = (words_left <= rate_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_SHAKE128;
            words_left    <= '0;
            last_q        <= 1'b0;
            state_reset_q <= 1'b0;
        end else begin
            state <= state_next;
            // Registered so the clear pulse is a Moore output of the first WAIT_BLOCK cycle
            state_reset_q <= (state == ST_IDLE) && start;
            if (state == ST_IDLE && start) begin
                mode_q     <= mode_t'(mode);
                words_left <= out_words;
            end
            if (state == ST_WAIT_BLOCK && input_buffer_ready) begin
                last_q <= last_block_in_buffer;
            end
            if (state == ST_SQUEEZE) begin
                words_left <= final_squeeze ? '0 : (words_left - rate_ext);
            end
        end
    end

    always_comb begin
        state_next            = state;
        input_buffer_consumed = 1'b0;
        absorb_enable         = 1'b0;
        round_enable          = 1'b0;
        round_index           = 5'd0;
        output_buffer_load    = 1'b0;
        last_output_block     = 1'b0;
        last_block_words      = 5'd0;
        done                  = 1'b0;
        cnt_clear             = 1'b0;
        cnt_en                = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_WAIT_BLOCK;
            end
            ST_WAIT_BLOCK: begin
                if (input_buffer_ready) state_next = ST_ABSORB;
            end
            ST_ABSORB: begin
                absorb_enable         = 1'b1;
                input_buffer_consumed = 1'b1;
                cnt_clear             = 1'b1;
                state_next            = ST_PERMUTE;
            end
            ST_PERMUTE: begin
                round_enable = 1'b1;
                round_index  = cnt;
                cnt_en       = 1'b1;
                if (cnt_last) begin
                    if (!last_q) begin
                        state_next = ST_WAIT_BLOCK;
                    end else if (words_left == '0) begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_SQUEEZE_WAIT;
                    end
                end
            end
            ST_SQUEEZE_WAIT: begin
                if (output_buffer_empty) state_next = ST_SQUEEZE;
            end
            ST_SQUEEZE: begin
                output_buffer_load = 1'b1;
                if (final_squeeze) begin
                    last_output_block = 1'b1;
                    last_block_words  = words_left[4:0];
                    done              = 1'b1;
                    state_next        = ST_IDLE;
                end else begin
                    cnt_clear  = 1'b1;
                    state_next = ST_PERMUTE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign state_reset = state_reset_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_shake_perm_ctrl.sv
// Directed bench for shake_perm_ctrl; round stepping follows SHAKE_DOUBLE_ROUND_EN.
module tb_shake_perm_ctrl;

`ifdef SHAKE_DOUBLE_ROUND_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int NR = 24 / STEP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] out_words;
    logic        input_buffer_ready;
    logic        last_block_in_buffer;
    logic        input_buffer_consumed;
    logic        state_reset;
    logic        absorb_enable;
    logic        round_enable;
    logic [4:0]  round_index;
    logic        output_buffer_empty;
    logic        output_buffer_load;
    logic        last_output_block;
    logic [4:0]  last_block_words;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    shake_perm_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .mode                  (mode),
        .out_words             (out_words),
        .input_buffer_ready    (input_buffer_ready),
        .last_block_in_buffer  (last_block_in_buffer),
        .input_buffer_consumed (input_buffer_consumed),
        .state_reset           (state_reset),
        .absorb_enable         (absorb_enable),
        .round_enable          (round_enable),
        .round_index           (round_index),
        .output_buffer_empty   (output_buffer_empty),
        .output_buffer_load    (output_buffer_load),
        .last_output_block     (last_output_block),
        .last_block_words      (last_block_words),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    wire [17:0] all_out = {input_buffer_consumed, state_reset, absorb_enable, round_enable,
                           round_index, output_buffer_load, last_output_block,
                           last_block_words, busy, done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (all_out !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_shake128_single();
        start = 1; mode = 0; out_words = 4;
        input_buffer_ready = 1; last_block_in_buffer = 1; output_buffer_empty = 1;
        tick();
        start = 0;
        n_tests++;
        if (state_reset !== 1'b1 || busy !== 1'b1 || absorb_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL s128_state_reset: sr=%b busy=%b abs=%b want 1 1 0", state_reset, busy, absorb_enable);
        end
        tick();
        input_buffer_ready = 0;
        n_tests++;
        if (absorb_enable !== 1'b1 || input_buffer_consumed !== 1'b1 || state_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL s128_absorb: abs=%b cons=%b sr=%b want 1 1 0", absorb_enable, input_buffer_consumed, state_reset);
        end
        for (int r = 0; r < NR; r++) begin
            tick();
            n_tests++;
            if (round_enable !== 1'b1 || round_index !== 5'(r * STEP) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL s128_round%0d: en=%b idx=%0d done=%b want 1 %0d 0", r, round_enable, round_index, done, r * STEP);
            end
        end
        tick();
        n_tests++;
        if (output_buffer_load !== 1'b0 || busy !== 1'b1 || round_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL s128_sqwait: load=%b busy=%b ren=%b want 0 1 0", output_buffer_load, busy, round_enable);
        end
        tick();
        n_tests++;
        if (output_buffer_load !== 1'b1 || last_output_block !== 1'b1 || last_block_words !== 5'd4 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL s128_squeeze: load=%b last=%b words=%0d done=%b want 1 1 4 1",
                     output_buffer_load, last_output_block, last_block_words, done);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL s128_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_shake256_multi();
        int cons = 0, rounds = 0, loads = 0, last_words = 0, last_loads = 0;
        bit done_seen = 0, done_with_last = 0;
        start = 1; mode = 1; out_words = 40;
        input_buffer_ready = 1; last_block_in_buffer = 0; output_buffer_empty = 1;
        tick();
        start = 0; mode = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            tick();
            if (input_buffer_consumed) cons++;
            if (round_enable) rounds++;
            if (output_buffer_load) begin
                loads++;
                if (last_output_block) begin
                    last_loads++;
                    last_words = last_block_words;
                    done_with_last = done;
                end
            end
            if (done) done_seen = 1;
            last_block_in_buffer = (cons >= 1);
        end
        input_buffer_ready = 0;
        n_tests++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL s256_timeout: done not seen within 400 cycles");
        end
        n_tests++;
        if (cons != 2) begin
            n_fail++;
            $display("FAIL s256_consumed: got %0d want 2", cons);
        end
        n_tests++;
        if (rounds != 4 * NR) begin
            n_fail++;
            $display("FAIL s256_rounds: got %0d want %0d", rounds, 4 * NR);
        end
        n_tests++;
        if (loads != 3 || last_loads != 1) begin
            n_fail++;
            $display("FAIL s256_loads: got %0d (last %0d) want 3 (1)", loads, last_loads);
        end
        n_tests++;
        if (last_words != 6 || !done_with_last) begin
            n_fail++;
            $display("FAIL s256_final: words=%0d done=%b want 6 1", last_words, done_with_last);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL s256_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_out();
        start = 1; mode = 0; out_words = 0;
        input_buffer_ready = 1; last_block_in_buffer = 1; output_buffer_empty = 1;
        tick();
        start = 0;
        tick();
        input_buffer_ready = 0;
        for (int r = 0; r < NR; r++) begin
            tick();
            n_tests++;
            if (output_buffer_load !== 1'b0 || done !== (r == NR - 1)) begin
                n_fail++;
                $display("FAIL zero_round%0d: load=%b done=%b want 0 %0b", r, output_buffer_load, done, (r == NR - 1));
            end
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || output_buffer_load !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: busy=%b load=%b want 0 0", busy, output_buffer_load);
        end
    endtask

    task automatic test_stall_and_start_ignored();
        start = 1; mode = 0; out_words = 25;
        input_buffer_ready = 1; last_block_in_buffer = 1; output_buffer_empty = 0;
        tick();
        start = 0;
        tick();
        input_buffer_ready = 0;
        for (int r = 0; r < NR; r++) tick();
        for (int s = 0; s < 7; s++) begin
            tick();
            start = (s == 2);
            out_words = (s == 2) ? 32'd3 : 32'd25;
            mode = (s == 2);
            n_tests++;
            if (output_buffer_load !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall%0d: load=%b busy=%b want 0 1", s, output_buffer_load, busy);
            end
        end
        start = 0; mode = 0;
        output_buffer_empty = 1;
        tick();
        n_tests++;
        if (output_buffer_load !== 1'b1 || last_output_block !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_first_load: load=%b last=%b done=%b want 1 0 0", output_buffer_load, last_output_block, done);
        end
        for (int r = 0; r < NR; r++) begin
            tick();
            n_tests++;
            if (round_enable !== 1'b1 || round_index !== 5'(r * STEP)) begin
                n_fail++;
                $display("FAIL stall_round%0d: en=%b idx=%0d want 1 %0d", r, round_enable, round_index, r * STEP);
            end
        end
        tick();
        tick();
        n_tests++;
        if (output_buffer_load !== 1'b1 || last_output_block !== 1'b1 || last_block_words !== 5'd4 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_final: load=%b last=%b words=%0d done=%b want 1 1 4 1",
                     output_buffer_load, last_output_block, last_block_words, done);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_permute();
        start = 1; mode = 0; out_words = 4;
        input_buffer_ready = 1; last_block_in_buffer = 1; output_buffer_empty = 1;
        tick();
        start = 0;
        tick();
        input_buffer_ready = 0;
        for (int r = 0; r <= 10 / STEP; r++) tick();
        n_tests++;
        if (round_enable !== 1'b1 || round_index !== 5'd10) begin
            n_fail++;
            $display("FAIL midrst_pre: en=%b idx=%0d want 1 10", round_enable, round_index);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if (all_out !== 18'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got %h want 0", all_out);
        end
        tick();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || round_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after%0d: busy=%b done=%b ren=%b want 0 0 0", c, busy, done, round_enable);
            end
        end
    endtask

    initial begin
        rst_n = 0; start = 0; mode = 0; out_words = 0;
        input_buffer_ready = 0; last_block_in_buffer = 0; output_buffer_empty = 0;
        #12;
        test_reset();
        test_shake128_single();
        test_shake256_multi();
        test_zero_out();
        test_stall_and_start_ignored();
        test_reset_mid_permute();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
